// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART receive types and default constants
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : 2-flop synchroniser for the serial line plus a delayed copy
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxIn,
  output logic rxS,
  output logic rxP
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All flops reset to the idle-line level so reset release never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= rxIn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rxS = r_sync;
  assign rxP = r_prev;

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// uart_rx_ctrl : UART receive front-end (start detect, mid-bit sampling, stop check)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxIn,
  output logic [DATA_BITS-1:0] dOut,
  output logic                 set,
  output logic                 stopOk,
  output logic                 busy
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_idx_w = $clog2(DATA_BITS + 1);

  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_rx_p;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_stop_ok;
  logic                 w_cnt_clr;
  logic                 w_cnt_en;
  logic                 w_idx_clr;
  logic                 w_shift_en;
  logic                 w_load;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rxIn  (rxIn),
    .rxS   (w_rx_s),
    .rxP   (w_rx_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_idx_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        // Falling edge only: a line held low never re-arms the receiver
        if (!w_rx_s && w_rx_p) begin
          w_state_nxt = START;
          w_cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_clr = 1'b1;
          if (w_rx_s) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
            w_idx_clr   = 1'b1;
          end
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == c_idx_last) w_state_nxt = STOP;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_clr   = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs load on DONE entry so they are already valid while set is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_stop_ok <= 1'b0;
    end else begin
      if (w_cnt_clr)     r_cnt <= '0;
      else if (w_cnt_en) r_cnt <= r_cnt + 1'b1;

      if (w_idx_clr)       r_idx <= '0;
      else if (w_shift_en) r_idx <= r_idx + 1'b1;

      if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};

      if (w_load) begin
        r_dout    <= r_shift;
        r_stop_ok <= w_rx_s;
      end
    end
  end

  assign dOut   = r_dout;
  assign stopOk = r_stop_ok;
  assign set    = (r_state == DONE);
  assign busy   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// tb_uart_rx_ctrl : scoreboard bench for the UART receive front-end
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

  localparam int N = 16;
  localparam int D = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rxIn  = 1'b1;
  logic [7:0] dOut;
  logic       set;
  logic       stopOk;
  logic       busy;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (N),
    .DATA_BITS    (D)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rxIn   (rxIn),
    .dOut   (dOut),
    .set    (set),
    .stopOk (stopOk),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_errors  = 0;
  logic [8:0] sb[$];
  int         cyc       = 0;
  int         busy_rise = 0;
  int         last_set  = -1;
  int         prev_set  = -1;
  logic       prev_busy = 1'b0;
  logic       chk_fall  = 1'b0;
  logic [8:0] e;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: which line bit is on rxS at each nominal sample point, given bit period p.
  // rxS falls one cycle before the first START cycle, so line bit j covers cycles [j*p-1, (j+1)*p-1).
  function automatic logic [8:0] model(logic [7:0] b, logic stp, int p);
    logic [8:0] r;
    int         t;
    int         idx;
    r = '0;
    for (int k = 0; k <= D; k++) begin
      t   = N / 2 + (k + 1) * N - 1;
      idx = (t + 1) / p;
      if (idx == 0)          r[k] = 1'b0;
      else if (idx <= D)     r[k] = b[idx-1];
      else if (idx == D + 1) r[k] = stp;
      else                   r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic send_frame(logic [7:0] b, logic stp, int p, bit expect_it);
    if (expect_it) sb.push_back(model(b, stp, p));
    rxIn = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < D; i++) begin
      rxIn = b[i];
      repeat (p) @(negedge clk);
    end
    rxIn = stp;
    repeat (p) @(negedge clk);
  endtask

  task automatic idle_bits(int n);
    rxIn = 1'b1;
    repeat (n * N) @(negedge clk);
  endtask

  // Monitor: every set strobe is matched against the oldest expected frame
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_busy = 1'b0;
      chk_fall  = 1'b0;
    end else begin
      if (chk_fall) begin
        check("busy_fall", int'(busy), 0);
        chk_fall = 1'b0;
      end
      if (busy && !prev_busy) busy_rise = cyc;
      prev_busy = busy;
      if (set) begin
        prev_set = last_set;
        last_set = cyc;
        check("set_latency", cyc - busy_rise, 152);
        check("set_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("dOut", int'(dOut), int'(e[7:0]));
          check("stopOk", int'(stopOk), int'(e[8]));
        end
        chk_fall = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stp;
    int         gap;
    int         bcnt;
    int         saw_busy;

    reset = 1'b1;
    rxIn  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dOut", int'(dOut), 0);
    check("rst_set", int'(set), 0);
    check("rst_stopOk", int'(stopOk), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    idle_bits(2);

    send_frame(8'hA5, 1'b1, N, 1'b1);
    idle_bits(2);

    send_frame(8'h3C, 1'b0, N, 1'b1);
    rxIn     = 1'b0;
    saw_busy = 0;
    repeat (40 * N) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    check("stuck_low_busy", saw_busy, 0);
    idle_bits(2);
    send_frame(8'h01, 1'b1, N, 1'b1);
    idle_bits(2);

    rxIn = 1'b0;
    repeat (4) @(negedge clk);
    rxIn = 1'b1;
    bcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    check("glitch_busy_seen", int'(bcnt > 0), 1);
    check("glitch_busy_max", int'(bcnt <= 8), 1);
    check("glitch_dOut", int'(dOut), 8'h01);
    idle_bits(1);

    send_frame(8'h00, 1'b1, N, 1'b1);
    send_frame(8'hFF, 1'b1, N, 1'b1);
    idle_bits(2);
    check("b2b_spacing", last_set - prev_set, 160);

    b    = 8'h55;
    rxIn = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxIn = b[i];
      repeat (N) @(negedge clk);
    end
    rxIn = b[4];
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    rxIn = 1'b1;
    #1;
    check("arst_dOut", int'(dOut), 0);
    check("arst_set", int'(set), 0);
    check("arst_stopOk", int'(stopOk), 0);
    check("arst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_bits(3);
    send_frame(8'hC3, 1'b1, N, 1'b1);
    idle_bits(2);

    send_frame(8'h96, 1'b1, 17, 1'b1);
    idle_bits(2);

    repeat (10) begin
      b   = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      gap = stp ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(b, stp, N, 1'b1);
      idle_bits(gap);
    end

    idle_bits(3);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive front-end of the UART receiver: synchronises the serial line, detects the start bit, samples data bits at mid-bit, and checks the stop bit. Sits directly upstream of the ready/error flag stage. Its `set` strobe and `stopOk` bit drive that stage's `set` and `dIn`, so a good stop bit raises data-ready and a bad one raises data-error. `dOut` carries the received byte to the consumer.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit (N); even, ≥ 4.
- DATA_BITS, default 8: data bits per frame (D); 5..8.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rxIn  in  1  raw serial line; idle high, asynchronous to clk.
- dOut  out  DATA_BITS  received data, LSB = first bit on the line.
- set  out  1  one-cycle strobe: frame complete, dOut/stopOk valid.
- stopOk  out  1  1 = stop bit sampled high, 0 = framing error.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- rxIn passes through a 2-flop synchroniser to give rxS; both flops reset to 1. A registered copy rxP (reset 1) supports edge detection.
- State machine, states IDLE, START, DATA, STOP, DONE:
  - IDLE: on rxS=0 with rxP=1 (falling edge), clear the counter and go to START. A line held low never re-triggers, so a break or stuck-low line is ignored until it returns high.
  - START: count 0..N/2−1. At N/2−1, sample rxS:
    - 0: clear the counter and bit index, go to DATA.
    - 1: glitch; go to IDLE with no strobe.
  - DATA: count 0..N−1. At N−1, shift rxS into the MSB of the internal shift register (right shift, LSB-first line order) and increment the bit index. After the D-th sample, go to STOP.
  - STOP: count 0..N−1. At N−1, register stopOk ← rxS and go to DONE.
  - DONE: one cycle. Assert set and load dOut ← shift register, then return to IDLE.
- dOut and stopOk hold their values until the next DONE. They are loaded even on a framing error.
- Counter width: $clog2(CLKS_PER_BIT). Bit-index width: $clog2(DATA_BITS+1). Neither counter may wrap inside a state.
- Asynchronous reset at any time, including mid-frame:
  - state → IDLE
  - dOut, shift register and counters → 0
  - set, stopOk, busy → 0
  - synchroniser flops and rxP → 1
  - A partially received frame is discarded with no strobe.

## Timing
- Cycle 0 is the first cycle in START. rxS is 2 clk after rxIn.
- Start bit sampled at cycle N/2−1.
- Data bit k (k = 0..D−1) sampled at cycle N/2 + (k+1)·N − 1.
- Stop bit sampled at cycle N/2 + (D+1)·N − 1.
- set is high for exactly one cycle, at cycle N/2 + (D+1)·N. dOut and stopOk are already valid in that cycle (registered in DONE entry).
- busy rises at cycle 0 and falls the cycle after DONE.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit + 2 cycles, so a start edge arriving N/2 later at the nominal frame boundary is caught. No minimum idle time is required.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, DONE)
  - default constants CLKS_PER_BIT_DEF = 16 and DATA_BITS_DEF = 8
- Sub-module uart_rx_sync holds the 2-flop synchroniser and the rxP edge register, with reset value 1.
- The FSM, counters and shift register live in uart_rx_ctrl.

## Test plan
All scenarios use N=16, D=8, with the bench driving rxIn at 16 clk per bit.
- Frame 0xA5 with stop=1 → one set pulse at cycle 152 after START entry; dOut=0xA5, stopOk=1; busy returns to 0 the next cycle.
- Frame 0x3C with stop=0 → one set pulse, dOut=0x3C, stopOk=0. Line then held low 40 bit-times → no further set, busy=0 throughout. Line released high, then frame 0x01 → dOut=0x01, stopOk=1.
- 4-cycle low glitch on idle line → busy high for ≤ 8 cycles, no set, dOut unchanged.
- Frames 0x00 then 0xFF sent with no idle gap → exactly two set pulses 160 cycles apart, dOut 0x00 then 0xFF, stopOk=1 both times.
- reset asserted for 3 cycles during data bit 4 of frame 0x55 → all outputs 0 immediately (asynchronous), no set. Next full frame 0xC3 → dOut=0xC3, stopOk=1.
- Sampling robustness: frame 0x96 with the bit period stretched to 17 clk → dOut=0x96, stopOk=1.
